// File: rtl/mp_alu_pkg.sv
// mp_alu_pkg: shared definitions for the multi-precision add/subtract path.
//   WORD_W        width of one adder word
//   mpas_state_t  sequencer states (IDLE, RUN, DONE)
//   OP_ADD/OP_SUB operation encoding carried on op_sub
package mp_alu_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mpas_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/mp_word_sel.sv
// mp_word_sel: combinational slice of word i_idx from two multi-word operands.
// Ports:
//   i_a, i_b   full-width operands (NWORDS x WORD_W)
//   i_idx      word index, 0 = least significant word
//   i_inv_b    invert the selected B word (upper words of a subtraction)
//   o_a_word   selected A word
//   o_b_word   selected B word, optionally inverted
module mp_word_sel
  import mp_alu_pkg::*;
#(
  parameter  int NWORDS = 4,
  localparam int IDXW   = $clog2(NWORDS)
) (
  input  logic [WORD_W*NWORDS-1:0] i_a,
  input  logic [WORD_W*NWORDS-1:0] i_b,
  input  logic [IDXW-1:0]          i_idx,
  input  logic                     i_inv_b,
  output logic [WORD_W-1:0]        o_a_word,
  output logic [WORD_W-1:0]        o_b_word
);

  logic [WORD_W-1:0] w_b_raw;

  assign o_a_word = i_a[WORD_W*i_idx +: WORD_W];
  assign w_b_raw  = i_b[WORD_W*i_idx +: WORD_W];
  assign o_b_word = i_inv_b ? ~w_b_raw : w_b_raw;

endmodule

// File: rtl/mp_addsub_seq.sv
// mp_addsub_seq: multi-precision add/subtract sequencer. Drives one external
// 32-bit addSub unit over NWORDS words, least significant word first, chaining
// carry/borrow and reporting final carry and signed overflow.
// Optional build macro: MPAS_ZERO_FLAG_EN adds output 'zero' (result == 0).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              request handshake (ready only in IDLE)
//   op_sub, op_signed, cin, a, b   operation and operands, latched on accept
//   out_valid/out_ready            result handshake
//   result, cout, ovf              sum/difference, top carry, signed overflow
//   zero                           (MPAS_ZERO_FLAG_EN only) result is all zeros
//   dbg_state                      current sequencer state
//   au_a, au_b, au_d, au_cin, au_si  drive to the addSub unit (0 outside RUN)
//   au_s, au_cout, au_v            addSub unit results
// Handshake: a transfer happens on a rising clk edge where valid && ready;
// valid, once raised, is held with stable data until that edge.
module mp_addsub_seq
  import mp_alu_pkg::*;
#(
  parameter  int NWORDS = 4,
  localparam int W      = WORD_W * NWORDS,
  localparam int IDXW   = $clog2(NWORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op_sub,
  input  logic              op_signed,
  input  logic              cin,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      result,
  output logic              cout,
  output logic              ovf,
`ifdef MPAS_ZERO_FLAG_EN
  output logic              zero,
`endif
  output logic [1:0]        dbg_state,
  output logic [WORD_W-1:0] au_a,
  output logic [WORD_W-1:0] au_b,
  output logic              au_d,
  output logic              au_cin,
  output logic              au_si,
  input  logic [WORD_W-1:0] au_s,
  input  logic              au_cout,
  input  logic              au_v
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  mpas_state_t       r_state;
  mpas_state_t       w_next_state;
  logic [IDXW-1:0]   r_idx;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic              r_op_sub;
  logic              r_op_signed;
  logic              r_cin;
  logic              r_carry;
  logic [W-1:0]      r_result;
  logic              r_cout;
  logic              r_ovf;

  logic              w_accept;
  logic              w_run;
  logic              w_first;
  logic              w_last;
  logic              w_is_sub;
  logic [WORD_W-1:0] w_a_word;
  logic [WORD_W-1:0] w_b_word;

  assign w_accept = in_valid && in_ready;
  assign w_run    = (r_state == RUN);
  assign w_first  = (r_idx == '0);
  assign w_last   = (r_idx == LAST_IDX);
  assign w_is_sub = (r_op_sub == OP_SUB);

  // Word 0 of a subtraction uses the adder's own subtract mode (A+~B+1);
  // upper words invert B here and add with the chained carry instead.
  mp_word_sel #(.NWORDS(NWORDS)) u_word_sel (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_idx    (r_idx),
    .i_inv_b  (w_is_sub && !w_first),
    .o_a_word (w_a_word),
    .o_b_word (w_b_word)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_next_state = RUN;
      RUN:     if (w_last)    w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default:                w_next_state = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    dbg_state = r_state;
  end

  // Adder drive; everything is forced to 0 outside RUN
  always_comb begin
    au_a   = '0;
    au_b   = '0;
    au_d   = 1'b0;
    au_cin = 1'b0;
    au_si  = 1'b0;
    if (w_run) begin
      au_a  = w_a_word;
      au_b  = w_b_word;
      au_d  = w_is_sub && w_first;
      au_si = r_op_signed && w_last;
      if (!w_first)                  au_cin = r_carry;
      else if (r_op_sub == OP_ADD)   au_cin = r_cin;
      else                           au_cin = 1'b0;
    end
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op_sub    <= 1'b0;
      r_op_signed <= 1'b0;
      r_cin       <= 1'b0;
      r_carry     <= 1'b0;
      r_result    <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a         <= a;
            r_b         <= b;
            r_op_sub    <= op_sub;
            r_op_signed <= op_signed;
            r_cin       <= cin;
            r_idx       <= '0;
            r_carry     <= 1'b0;
          end
        end
        RUN: begin
          r_result[WORD_W*r_idx +: WORD_W] <= au_s;
          r_carry <= au_cout;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_cout <= au_cout;
            r_ovf  <= r_op_signed & au_v;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;

`ifdef MPAS_ZERO_FLAG_EN
  logic r_zero;

  always_ff @(posedge clk) begin
    if (rst)                        r_zero <= 1'b0;
    else if (w_accept)              r_zero <= 1'b1;
    else if (w_run && au_s != '0)   r_zero <= 1'b0;
  end

  assign zero = r_zero;
`endif

endmodule

// File: tb/tb_mp_addsub_seq.sv
module tb_mp_addsub_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- 2-word instance ----------------
  logic         in_valid2 = 0, in_ready2, op_sub2 = 0, op_signed2 = 0, cin2 = 0;
  logic [63:0]  a2 = '0, b2 = '0, result2;
  logic         out_valid2, out_ready2 = 0, cout2, ovf2;
  logic [1:0]   st2;
  logic [31:0]  au_a2, au_b2, au_s2;
  logic         au_d2, au_cin2, au_si2, au_cout2, au_v2;
`ifdef MPAS_ZERO_FLAG_EN
  logic         zero2;
`endif

  // ---------------- 4-word instance ----------------
  logic         in_valid4 = 0, in_ready4, op_sub4 = 0, op_signed4 = 0, cin4 = 0;
  logic [127:0] a4 = '0, b4 = '0, result4;
  logic         out_valid4, out_ready4 = 0, cout4, ovf4;
  logic [1:0]   st4;
  logic [31:0]  au_a4, au_b4, au_s4;
  logic         au_d4, au_cin4, au_si4, au_cout4, au_v4;
`ifdef MPAS_ZERO_FLAG_EN
  logic         zero4;
`endif

  // Reference addSub unit: D=1 -> A+~B+1, D=0 -> A+B+Cin; V only when Si.
  function automatic logic [33:0] addsub_model(input logic [31:0] x, y,
                                               input logic d, c, si);
    logic [31:0] ye;
    logic [32:0] t;
    logic        v;
    ye = d ? ~y : y;
    t  = {1'b0, x} + {1'b0, ye} + {32'b0, (d ? 1'b1 : c)};
    v  = si & (x[31] == ye[31]) & (t[31] != x[31]);
    return {v, t[32], t[31:0]};
  endfunction

  assign {au_v2, au_cout2, au_s2} = addsub_model(au_a2, au_b2, au_d2, au_cin2, au_si2);
  assign {au_v4, au_cout4, au_s4} = addsub_model(au_a4, au_b4, au_d4, au_cin4, au_si4);

  mp_addsub_seq #(.NWORDS(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .op_sub(op_sub2), .op_signed(op_signed2), .cin(cin2), .a(a2), .b(b2),
    .out_valid(out_valid2), .out_ready(out_ready2), .result(result2),
    .cout(cout2), .ovf(ovf2),
`ifdef MPAS_ZERO_FLAG_EN
    .zero(zero2),
`endif
    .dbg_state(st2), .au_a(au_a2), .au_b(au_b2), .au_d(au_d2),
    .au_cin(au_cin2), .au_si(au_si2), .au_s(au_s2), .au_cout(au_cout2),
    .au_v(au_v2)
  );

  mp_addsub_seq #(.NWORDS(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .op_sub(op_sub4), .op_signed(op_signed4), .cin(cin4), .a(a4), .b(b4),
    .out_valid(out_valid4), .out_ready(out_ready4), .result(result4),
    .cout(cout4), .ovf(ovf4),
`ifdef MPAS_ZERO_FLAG_EN
    .zero(zero4),
`endif
    .dbg_state(st4), .au_a(au_a4), .au_b(au_b4), .au_d(au_d4),
    .au_cin(au_cin4), .au_si(au_si4), .au_s(au_s4), .au_cout(au_cout4),
    .au_v(au_v4)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation on the 2-word instance; called with the DUT idle.
  task automatic op2(input string tag, input logic [63:0] a, b,
                     input logic sub, sgn, ci,
                     input logic [63:0] exp_r, input logic exp_c, exp_v);
    int n;
    in_valid2 = 1; a2 = a; b2 = b; op_sub2 = sub; op_signed2 = sgn; cin2 = ci;
    tick();
    in_valid2 = 0;
    a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom}; cin2 = ~ci;
    chk({tag, "_in_ready_run"}, in_ready2, 0);
    chk({tag, "_au_d_w0"}, au_d2, sub);
    n = 0;
    while (!out_valid2 && n < 20) begin tick(); n++; end
    chk({tag, "_latency"}, n, 2);
    chk({tag, "_result"}, result2, exp_r);
    chk({tag, "_cout"}, cout2, exp_c);
    chk({tag, "_ovf"}, ovf2, exp_v);
`ifdef MPAS_ZERO_FLAG_EN
    chk({tag, "_zero"}, zero2, (exp_r == 64'd0));
`endif
    out_ready2 = 1;
    tick();
    out_ready2 = 0;
    chk({tag, "_idle_after"}, {out_valid2, in_ready2}, 2'b01);
  endtask

  task automatic op4(input string tag, input logic [127:0] a, b,
                     input logic sub, sgn, ci,
                     input logic [127:0] exp_r, input logic exp_c, exp_v);
    int n;
    in_valid4 = 1; a4 = a; b4 = b; op_sub4 = sub; op_signed4 = sgn; cin4 = ci;
    tick();
    in_valid4 = 0;
    a4 = '0; b4 = '1;
    n = 0;
    while (!out_valid4 && n < 20) begin tick(); n++; end
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_result"}, result4, exp_r);
    chk({tag, "_cout"}, cout4, exp_c);
    chk({tag, "_ovf"}, ovf4, exp_v);
    out_ready4 = 1;
    tick();
    out_ready4 = 0;
    chk({tag, "_idle_after"}, {out_valid4, in_ready4}, 2'b01);
  endtask

  initial begin : main
    logic [63:0]  held;
    logic [127:0] ones128;
    int           n;
    ones128 = '1;

    // Reset
    rst = 1;
    tick(); tick();
    rst = 0;
    chk("rst_in_ready2", in_ready2, 1);
    chk("rst_out_valid2", out_valid2, 0);
    chk("rst_result2", result2, 0);
    chk("rst_cout_ovf2", {cout2, ovf2}, 0);
    chk("rst_au2", {au_a2, au_b2, au_d2, au_cin2, au_si2}, 0);
    chk("rst_result4", result4, 0);
    chk("rst_in_ready4", in_ready4, 1);

    // 2-word directed vectors
    op2("add_carry", 64'h0000_0000_FFFF_FFFF, 64'd1, 0, 0, 0,
        64'h0000_0001_0000_0000, 0, 0);
    op2("add_cin", 64'd1, 64'd2, 0, 0, 1, 64'd4, 0, 0);
    op2("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 0, 64'd0, 1, 0);
    op2("sub_0m1", 64'd0, 64'd1, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    op2("sub_5m3", 64'd5, 64'd3, 1, 0, 1, 64'd2, 1, 0);
    op2("sadd_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 1, 0,
        64'h8000_0000_0000_0000, 0, 1);
    op2("uadd_noovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 0,
        64'h8000_0000_0000_0000, 0, 0);
    op2("sub_equal", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1, 1, 0,
        64'd0, 1, 0);

    // 4-word signed subtraction
    op4("ssub_min", ones128, 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1, 1, 0,
        128'h8000_0000_0000_0000_0000_0000_0000_0000, 1, 0);
    op4("ssub_ovf", {ones128[127:1], 1'b0},
        128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1, 1, 0,
        128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1, 1);

    // Back-pressure: result held while out_ready stays low
    in_valid2 = 1; a2 = 64'h0000_0001_0000_0000; b2 = 64'd1;
    op_sub2 = 1; op_signed2 = 0; cin2 = 0;
    tick();
    a2 = 64'd100; b2 = 64'd1; op_sub2 = 0;   // keep requesting during busy
    n = 0;
    while (!out_valid2 && n < 20) begin tick(); n++; end
    chk("bp_latency", n, 2);
    held = result2;
    chk("bp_result", held, 64'h0000_0000_FFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_result", result2, 64'h0000_0000_FFFF_FFFF);
      chk("bp_hold_flags", {out_valid2, in_ready2, cout2}, 3'b101);
    end
    // Release; the still-asserted request is accepted back-to-back
    a2 = 64'd5; b2 = 64'd3; op_sub2 = 1;
    out_ready2 = 1;
    tick();
    out_ready2 = 0;
    chk("bb_idle", {out_valid2, in_ready2}, 2'b01);
    tick();
    in_valid2 = 0;
    chk("bb_accepted", in_ready2, 0);
    n = 0;
    while (!out_valid2 && n < 20) begin tick(); n++; end
    chk("bb_latency", n, 2);
    chk("bb_result", result2, 64'd2);
    chk("bb_cout", cout2, 1);
    out_ready2 = 1;
    tick();
    out_ready2 = 0;

    // Reset in the middle of an operation (word 1 of 4)
    in_valid4 = 1; a4 = 128'd7; b4 = 128'd9; op_sub4 = 0; op_signed4 = 0; cin4 = 0;
    tick();
    in_valid4 = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("mrst_in_ready", in_ready4, 1);
    chk("mrst_out_valid", out_valid4, 0);
    chk("mrst_result", result4, 0);
    chk("mrst_au", {au_a4, au_b4, au_d4, au_cin4, au_si4}, 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid4) n++;
    end
    chk("mrst_no_result", n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
